// File: rtl/econet_tx_scheduler.sv
// Two-requester scheduler for the buffered Econet transmitter: writes frame_start then buffer_end, and tracks tx_busy until the frame completes.
// Optional watchdog on the busy phases is enabled with `define ECONET_TXSCHED_TIMEOUT_EN.
module econet_tx_scheduler #(
   parameter int ECO_CNTWIDTH = 9,
   parameter int TMO_WIDTH    = 20,
   parameter int BUSY_TIMEOUT = 4096,
   parameter int DONE_TIMEOUT = 1000000
) (
   input  logic                    sys_clk,
   input  logic                    reset_n,
   input  logic [1:0]              req_valid,
   input  logic [ECO_CNTWIDTH-1:0] req_start0,
   input  logic [ECO_CNTWIDTH-1:0] req_start1,
   input  logic [ECO_CNTWIDTH-1:0] req_end0,
   input  logic [ECO_CNTWIDTH-1:0] req_end1,
   output logic [1:0]              req_ready,
   output logic [1:0]              done,
   output logic [1:0]              error,
   input  logic                    tx_busy,
   output logic [3:0]              tx_we,
   output logic [31:0]             tx_data,
   output logic                    tx_select_frame_start,
   output logic                    tx_select_buffer_end,
   output logic                    sched_busy,
   output logic                    owner,
   output logic [2:0]              fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_WR_START, S_WR_END, S_WAIT_BUSY, S_WAIT_DONE, S_COMPLETE
   } state_t;

   state_t                  state, state_nx;
   logic [ECO_CNTWIDTH-1:0] start_q, end_q;
   logic                    last_owner;
   logic                    busy_m, busy_s;
   logic                    grant_vld, grant_idx;
   logic                    fail, finish;
   logic                    tmo_hit;

   // Handshake: a requester holds req_valid and its descriptor steady; the
   // descriptor is taken on the edge closing the cycle where req_ready pulses.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 1'b0;
      if (reset_n && state == S_IDLE) begin
         case (req_valid)
            2'b01: begin grant_vld = 1'b1; grant_idx = 1'b0;        end
            2'b10: begin grant_vld = 1'b1; grant_idx = 1'b1;        end
            2'b11: begin grant_vld = 1'b1; grant_idx = ~last_owner; end
            default: ;
         endcase
      end
   end

   assign req_ready  = grant_vld ? (2'b01 << grant_idx) : 2'b00;
   assign sched_busy = (state != S_IDLE);
   assign fsm_state  = state;

   always_comb begin
      state_nx = state;
      fail     = 1'b0;
      finish   = 1'b0;
      case (state)
         S_IDLE:      if (grant_vld) state_nx = S_CHECK;
         S_CHECK:
            if (end_q < start_q) begin
               fail     = 1'b1;
               state_nx = S_IDLE;
            end else begin
               state_nx = S_WR_START;
            end
         S_WR_START:  state_nx = S_WR_END;
         S_WR_END:    state_nx = S_WAIT_BUSY;
         // A watchdog expiry wins over a simultaneous busy_s edge.
         S_WAIT_BUSY:
            if (tmo_hit) begin
               fail     = 1'b1;
               state_nx = S_IDLE;
            end else if (busy_s) begin
               state_nx = S_WAIT_DONE;
            end
         S_WAIT_DONE:
            if (tmo_hit) begin
               fail     = 1'b1;
               state_nx = S_IDLE;
            end else if (!busy_s) begin
               state_nx = S_COMPLETE;
            end
         S_COMPLETE: begin
            finish   = 1'b1;
            state_nx = S_IDLE;
         end
         default:     state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      tx_we                 = 4'h0;
      tx_data               = 32'h0;
      tx_select_frame_start = 1'b0;
      tx_select_buffer_end  = 1'b0;
      case (state)
         S_WR_START: begin
            tx_select_frame_start = 1'b1;
            tx_we                 = 4'hF;
            tx_data               = 32'(start_q);
         end
         S_WR_END: begin
            tx_select_buffer_end = 1'b1;
            tx_we                = 4'hF;
            tx_data              = 32'(end_q);
         end
         default: ;
      endcase
   end

   // done/error are registered: they appear the cycle after the deciding state.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         start_q    <= '0;
         end_q      <= '0;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         busy_m     <= 1'b0;
         busy_s     <= 1'b0;
         done       <= 2'b00;
         error      <= 2'b00;
      end else begin
         state  <= state_nx;
         busy_m <= tx_busy;
         busy_s <= busy_m;
         done   <= 2'b00;
         error  <= 2'b00;
         if (grant_vld) begin
            owner   <= grant_idx;
            start_q <= grant_idx ? req_start1 : req_start0;
            end_q   <= grant_idx ? req_end1 : req_end0;
         end
         if (finish) begin
            done       <= 2'b01 << owner;
            last_owner <= owner;
         end
         if (fail) begin
            error      <= 2'b01 << owner;
            last_owner <= owner;
         end
      end
   end

`ifdef ECONET_TXSCHED_TIMEOUT_EN
   logic [TMO_WIDTH-1:0] wdt;

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n)
         wdt <= '0;
      else if (state_nx != state)
         wdt <= '0;
      else if (state == S_WAIT_BUSY || state == S_WAIT_DONE)
         wdt <= wdt + TMO_WIDTH'(1);
   end

   assign tmo_hit = (state == S_WAIT_BUSY && wdt == TMO_WIDTH'(BUSY_TIMEOUT - 1)) ||
                    (state == S_WAIT_DONE && wdt == TMO_WIDTH'(DONE_TIMEOUT - 1));
`else
   logic unused_tmo_cfg;

   assign unused_tmo_cfg = ^{TMO_WIDTH[0], BUSY_TIMEOUT[0], DONE_TIMEOUT[0]};
   assign tmo_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_econet_tx_scheduler.sv
// Self-checking bench for econet_tx_scheduler: directed scenarios plus randomized
// descriptor phases scored against an event-level model of the scheduler.
module tb_econet_tx_scheduler;

   localparam int         EW       = 16;
   localparam logic [3:0] EV_GRANT = 4'd1;
   localparam logic [3:0] EV_WRS   = 4'd2;
   localparam logic [3:0] EV_WRE   = 4'd3;
   localparam logic [3:0] EV_DONE  = 4'd4;
   localparam logic [3:0] EV_ERR   = 4'd5;

   logic        sys_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [8:0]  req_start0 = '0, req_start1 = '0, req_end0 = '0, req_end1 = '0;
   logic [1:0]  req_ready, done, error;
   logic        tx_busy = 1'b0;
   logic [3:0]  tx_we;
   logic [31:0] tx_data;
   logic        tx_select_frame_start, tx_select_buffer_end;
   logic        sched_busy, owner;
   logic [2:0]  fsm_state_unused;

   econet_tx_scheduler #(
      .ECO_CNTWIDTH(9), .TMO_WIDTH(20), .BUSY_TIMEOUT(16), .DONE_TIMEOUT(300)
   ) dut (
      .sys_clk(sys_clk), .reset_n(reset_n), .req_valid(req_valid),
      .req_start0(req_start0), .req_start1(req_start1),
      .req_end0(req_end0), .req_end1(req_end1),
      .req_ready(req_ready), .done(done), .error(error), .tx_busy(tx_busy),
      .tx_we(tx_we), .tx_data(tx_data),
      .tx_select_frame_start(tx_select_frame_start),
      .tx_select_buffer_end(tx_select_buffer_end),
      .sched_busy(sched_busy), .owner(owner), .fsm_state(fsm_state_unused)
   );

   always #5 sys_clk = ~sys_clk;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [EW-1:0] exp_q[$];
   int            cyc = 0, t_accept = 0, t_wr_end = 0;
   bit            chk_err_lat = 0, chk_tmo_lat = 0, own_chk_en = 0;
   int            tx_state = 0, tx_dly = 0, tx_hi = 0, tx_d1 = 0, tx_d2 = 4;
   bit            tx_auto = 1;
   logic          mdl_last = 1'b1;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [EW-1:0] mk_ev(input logic [3:0] k, input logic o, input logic [8:0] p);
      return {k, o, 2'b00, p};
   endfunction

   task automatic see_event(input logic [EW-1:0] ev);
      if (exp_q.size() == 0) check_eq("unexpected_event", 64'(ev), 64'd0);
      else                   check_eq("event", 64'(ev), 64'(exp_q.pop_front()));
   endtask

   // Model: one frame yields grant, then either error, or two writes and done.
   task automatic push_frame(input logic g, input logic [8:0] s, input logic [8:0] e, input bit tmo);
      logic [8:0] onehot;
      onehot = g ? 9'd2 : 9'd1;
      exp_q.push_back(mk_ev(EV_GRANT, 1'b0, onehot));
      if (e < s) begin
         exp_q.push_back(mk_ev(EV_ERR, 1'b0, onehot));
      end else begin
         exp_q.push_back(mk_ev(EV_WRS, g, s));
         exp_q.push_back(mk_ev(EV_WRE, g, e));
         exp_q.push_back(mk_ev(tmo ? EV_ERR : EV_DONE, 1'b0, onehot));
      end
      mdl_last = g;
   endtask

   task automatic tick();
      logic [1:0] clr_valid;
      @(negedge sys_clk);
      cyc++;
      clr_valid = req_ready;
      check_eq("sel_excl", 64'(tx_select_frame_start & tx_select_buffer_end), 64'd0);
      if (!tx_select_frame_start && !tx_select_buffer_end) begin
         check_eq("bus_idle", {28'd0, tx_we, tx_data}, 64'd0);
      end else begin
         check_eq("we", 64'(tx_we), 64'hF);
         check_eq("data_hi", 64'(tx_data[31:9]), 64'd0);
      end
      if (own_chk_en && sched_busy) check_eq("owner_hold", 64'(owner), 64'd0);
      if (done != 2'b00) see_event(mk_ev(EV_DONE, 1'b0, {7'd0, done}));
      if (error != 2'b00) begin
         see_event(mk_ev(EV_ERR, 1'b0, {7'd0, error}));
         if (chk_err_lat) check_eq("err_latency", 64'(cyc - t_accept), 64'd2);
         if (chk_tmo_lat) check_eq("tmo_latency", 64'(cyc - t_wr_end), 64'd17);
      end
      if (req_ready != 2'b00) begin
         see_event(mk_ev(EV_GRANT, 1'b0, {7'd0, req_ready}));
         t_accept = cyc;
      end
      if (tx_select_frame_start) see_event(mk_ev(EV_WRS, owner, tx_data[8:0]));
      if (tx_select_buffer_end) begin
         see_event(mk_ev(EV_WRE, owner, tx_data[8:0]));
         t_wr_end = cyc;
         if (tx_auto) begin
            tx_state = 1; tx_dly = tx_d1; tx_hi = tx_d2;
         end
      end
      @(posedge sys_clk);
      #1;
      req_valid = req_valid & ~clr_valid;
      if (tx_state == 1) begin
         if (tx_dly == 0) begin tx_busy = 1'b1; tx_state = 2; end
         else tx_dly--;
      end else if (tx_state == 2) begin
         tx_hi--;
         if (tx_hi == 0) begin tx_busy = 1'b0; tx_state = 0; end
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      int pend;
      while (!(exp_q.size() == 0 && req_valid == 2'b00 && !sched_busy && tx_state == 0)) begin
         if (n == budget) begin
            pend = exp_q.size();
            check_eq("idle_timeout", {32'(pend), 28'd0, sched_busy, req_valid, tx_state != 0}, 64'd0);
            exp_q.delete();
            req_valid = 2'b00;
            return;
         end
         tick();
         n++;
      end
   endtask

   task automatic run_phase(input logic [1:0] m, input logic [8:0] s0, input logic [8:0] e0,
                            input logic [8:0] s1, input logic [8:0] e1);
      logic g0;
      g0 = (m == 2'b11) ? ~mdl_last : m[1];
      push_frame(g0, g0 ? s1 : s0, g0 ? e1 : e0, 1'b0);
      if (m == 2'b11) push_frame(~g0, g0 ? s0 : s1, g0 ? e0 : e1, 1'b0);
      req_start0 = s0; req_end0 = e0;
      req_start1 = s1; req_end1 = e1;
      req_valid  = m;
      wait_idle(600);
   endtask

   task automatic rand_desc(output logic [8:0] s, output logic [8:0] e);
      int si;
      si = $urandom_range(0, 511);
      if (si > 0 && $urandom_range(0, 3) == 0) e = 9'($urandom_range(0, si - 1));
      else if ($urandom_range(0, 3) == 0)      e = 9'(si);
      else                                     e = 9'($urandom_range(si, 511));
      s = 9'(si);
   endtask

   initial begin
      logic [8:0] s0, e0, s1, e1;
      int         pend;

      // Reset with both requesters already valid: nothing may be granted yet.
      req_valid  = 2'b11;
      req_start0 = 9'h010; req_end0 = 9'h020;
      req_start1 = 9'h030; req_end1 = 9'h040;
      repeat (3) @(posedge sys_clk);
      #1;
      check_eq("reset_outputs", {18'd0, req_ready, done, error, tx_we, tx_data,
               tx_select_frame_start, tx_select_buffer_end, sched_busy, owner}, 64'd0);
      reset_n = 1'b1;

      // Contention from reset: 0 then 1, then 0 again when both re-assert.
      run_phase(2'b11, 9'h010, 9'h020, 9'h030, 9'h040);
      run_phase(2'b11, 9'h050, 9'h060, 9'h070, 9'h080);

      // Single frame with a long busy period.
      tx_d1 = 0; tx_d2 = 50; own_chk_en = 1;
      run_phase(2'b01, 9'h000, 9'h00F, 9'h000, 9'h000);
      own_chk_en = 0;

      // Bad descriptor on requester 1.
      chk_err_lat = 1;
      run_phase(2'b10, 9'h000, 9'h000, 9'h100, 9'h0FF);
      chk_err_lat = 0;
      check_eq("idle_after_err", 64'(sched_busy), 64'd0);

      // Edge cases: last byte index, then a one-cycle busy glitch.
      tx_d1 = 1; tx_d2 = 3;
      run_phase(2'b01, 9'h1FF, 9'h1FF, 9'h000, 9'h000);
      tx_d1 = 0; tx_d2 = 1;
      run_phase(2'b10, 9'h000, 9'h000, 9'h005, 9'h009);

      // Transmitter never goes busy.
      tx_auto = 0;
      req_start0 = 9'h010; req_end0 = 9'h020;
`ifdef ECONET_TXSCHED_TIMEOUT_EN
      push_frame(1'b0, 9'h010, 9'h020, 1'b1);
      chk_tmo_lat = 1;
      req_valid   = 2'b01;
      wait_idle(200);
      chk_tmo_lat = 0;
`else
      push_frame(1'b0, 9'h010, 9'h020, 1'b0);
      req_valid = 2'b01;
      repeat (40) tick();
      check_eq("wait_busy_hold", {62'd0, sched_busy, error != 2'b00}, 64'd2);
      tx_state = 1; tx_dly = 0; tx_hi = 3;
      wait_idle(200);
`endif
      tx_auto = 1;

      // Reset asserted while the frame sits in the busy-fall wait.
      tx_d1 = 0; tx_d2 = 30;
      push_frame(1'b1, 9'h003, 9'h028, 1'b0);
      req_start1 = 9'h003; req_end1 = 9'h028;
      req_valid  = 2'b10;
      repeat (12) tick();
      check_eq("mid_frame_busy", 64'(sched_busy), 64'd1);
      pend = exp_q.size();
      check_eq("pending_before_rst", 64'(pend), 64'd1);
      reset_n = 1'b0;
      #1;
      check_eq("rst_mid_outputs", {18'd0, req_ready, done, error, tx_we, tx_data,
               tx_select_frame_start, tx_select_buffer_end, sched_busy, owner}, 64'd0);
      exp_q.delete();
      mdl_last  = 1'b1;
      tx_state  = 0;
      tx_busy   = 1'b0;
      req_valid = 2'b00;
      repeat (3) tick();
      reset_n = 1'b1;
      tx_d1 = 2; tx_d2 = 4;
      run_phase(2'b11, 9'h020, 9'h021, 9'h040, 9'h041);

      // Randomized phases.
      for (int i = 0; i < 40; i++) begin
         tx_d1 = $urandom_range(0, 5);
         tx_d2 = $urandom_range(1, 8);
         rand_desc(s0, e0);
         rand_desc(s1, e1);
         run_phase(2'($urandom_range(1, 3)), s0, e0, s1, e1);
      end

      pend = exp_q.size();
      check_eq("queue_drained", 64'(pend), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
